// File: rtl/smem_rd_arbiter_pkg.sv
// Shared types for the SMEM read arbiter: the CCI-P c0 header subset, the mdata tag layout
// and the helpers that pack and unpack the tag.
package smem_arb_pkg;

    localparam int CCIP_CLADDR_W = 42;
    localparam int CCIP_MDATA_W  = 16;

    localparam int ARB_ID_W    = 3;
    localparam int ARB_SEQ_W   = 8;
    localparam int ARB_ID_LSB  = 13;
    localparam int ARB_ID_MSB  = ARB_ID_LSB + ARB_ID_W - 1;
    localparam int ARB_SEQ_LSB = 0;
    localparam int ARB_SEQ_MSB = ARB_SEQ_LSB + ARB_SEQ_W - 1;

    typedef logic [CCIP_CLADDR_W-1:0] t_ccip_clAddr;
    typedef logic [CCIP_MDATA_W-1:0]  t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        logic [ARB_ID_W-1:0]  id;
        logic [ARB_SEQ_W-1:0] seq;
    } t_arb_tag;

    function automatic t_ccip_mdata arb_pack_mdata(input t_arb_tag tag);
        t_ccip_mdata m;
        m = '0;
        m[ARB_ID_MSB:ARB_ID_LSB]   = tag.id;
        m[ARB_SEQ_MSB:ARB_SEQ_LSB] = tag.seq;
        return m;
    endfunction

    function automatic t_arb_tag arb_unpack_mdata(input t_ccip_mdata m);
        t_arb_tag tag;
        tag.id  = m[ARB_ID_MSB:ARB_ID_LSB];
        tag.seq = m[ARB_SEQ_MSB:ARB_SEQ_LSB];
        return tag;
    endfunction

endpackage

// File: rtl/smem_rd_arbiter_if.sv
// Requester-side and CCI-P c0-side signals of the SMEM read arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface smem_rd_arbiter_if
    import smem_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_OUT = 16,
    parameter int ADDR_W  = 42
);
    localparam int SEQ_W = $clog2(MAX_OUT);

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]             req_ready;

    logic                         spl_tx_rd_almostfull;
    logic                         afu_tx_rd_valid;
    t_ccip_c0_ReqMemHdr           afu_tx_rd_hdr;

    logic                         spl_rx_rd_valid;
    t_ccip_c0_RspMemHdr           spl_rx_rd_hdr;
    logic [511:0]                 spl_rx_data;

    logic [N_REQ-1:0]             rsp_valid;
    logic [511:0]                 rsp_data;
    logic [SEQ_W-1:0]             rsp_seq;
    logic                         idle;
    logic                         err_bad_id;

    modport slave (
        input  req_valid, req_addr, spl_tx_rd_almostfull,
               spl_rx_rd_valid, spl_rx_rd_hdr, spl_rx_data,
        output req_ready, afu_tx_rd_valid, afu_tx_rd_hdr,
               rsp_valid, rsp_data, rsp_seq, idle, err_bad_id
    );

    modport master (
        output req_valid, req_addr, spl_tx_rd_almostfull,
               spl_rx_rd_valid, spl_rx_rd_hdr, spl_rx_data,
        input  req_ready, afu_tx_rd_valid, afu_tx_rd_hdr,
               rsp_valid, rsp_data, rsp_seq, idle, err_bad_id
    );

endinterface

// File: rtl/smem_rr_arbiter.sv
// Pure combinational round-robin grant: first eligible index at or after ptr, wrapping.
// Shared between the read and write SMEM arbiters.
module smem_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grantIdx
);

    always_comb begin
        int  idx;
        logic found;
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (enable && !found && eligible[idx]) begin
                grant[idx] = 1'b1;
                grantIdx   = IDX_W'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smem_rd_arbiter.sv
// Round-robin sharing of the CCI-P c0 read channel among SMEM requesters, with per-requester
// credit limits, mdata tagging {id, seq} and response steering back to the issuing requester.
module smem_rd_arbiter
    import smem_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_OUT = 16,
    parameter int ADDR_W  = 42
) (
    input  logic              clk,
    input  logic              spl_reset_n,
    smem_rd_arbiter_if.slave  rdBus
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int SEQ_W  = $clog2(MAX_OUT);
    localparam int CRED_W = SEQ_W + 1;

    logic [N_REQ-1:0][CRED_W-1:0] credits;
    logic [N_REQ-1:0][SEQ_W-1:0]  seqCnt;
    logic [IDX_W-1:0]             rrPtr;

    logic [N_REQ-1:0]             eligible;
    logic [N_REQ-1:0]             grant;
    logic [IDX_W-1:0]             grantIdx;
    logic                         issueEn;
    logic                         accept;
    logic [IDX_W-1:0]             nextPtr;

    t_arb_tag                     issueTag;
    t_ccip_c0_ReqMemHdr           nextHdr;
    t_ccip_c0_ReqMemHdr           hdrQ;
    logic                         afuValidQ;

    t_arb_tag                     rxTag;
    logic [N_REQ-1:0]             rspHit;
    logic                         rspOk;
    logic                         badRsp;
    logic [N_REQ-1:0]             rspValidQ;
    logic [511:0]                 rspDataQ;
    logic [SEQ_W-1:0]             rspSeqQ;
    logic                         errQ;

    // ---------------- request side ----------------
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++)
            eligible[i] = rdBus.req_valid[i] && (credits[i] < CRED_W'(MAX_OUT));
    end

    // Almost-full gates the grant in the same cycle; MPF slack covers the registered request.
    assign issueEn = !rdBus.spl_tx_rd_almostfull;

    smem_rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) uRr (
        .eligible (eligible),
        .ptr      (rrPtr),
        .enable   (issueEn),
        .grant    (grant),
        .grantIdx (grantIdx)
    );

    assign accept          = |grant;
    assign rdBus.req_ready = grant;
    assign nextPtr         = (grantIdx == IDX_W'(N_REQ - 1)) ? '0 : grantIdx + IDX_W'(1);

    always_comb begin
        issueTag.id  = ARB_ID_W'(grantIdx);
        issueTag.seq = ARB_SEQ_W'(seqCnt[grantIdx]);
        nextHdr          = '0;
        nextHdr.vc_sel   = eVC_VA;
        nextHdr.cl_len   = eCL_LEN_1;
        nextHdr.req_type = eREQ_RDLINE_S;
        nextHdr.address  = CCIP_CLADDR_W'(rdBus.req_addr[grantIdx]);
        nextHdr.mdata    = arb_pack_mdata(issueTag);
    end

    // ---------------- response side ----------------
    assign rxTag = arb_unpack_mdata(rdBus.spl_rx_rd_hdr.mdata);

    // A response only counts if it names a real requester that actually has a read out.
    always_comb begin
        rspHit = '0;
        for (int i = 0; i < N_REQ; i++)
            rspHit[i] = rdBus.spl_rx_rd_valid && (rxTag.id == ARB_ID_W'(i)) && (credits[i] != '0);
    end

    assign rspOk  = |rspHit;
    assign badRsp = rdBus.spl_rx_rd_valid && !rspOk;

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (!spl_reset_n) begin
            credits   <= '0;
            seqCnt    <= '0;
            rrPtr     <= '0;
            afuValidQ <= 1'b0;
            hdrQ      <= '0;
            rspValidQ <= '0;
            rspDataQ  <= '0;
            rspSeqQ   <= '0;
            errQ      <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                case ({grant[i], rspHit[i]})
                    2'b10:   credits[i] <= credits[i] + CRED_W'(1);
                    2'b01:   credits[i] <= credits[i] - CRED_W'(1);
                    default: credits[i] <= credits[i];
                endcase
                if (grant[i])
                    seqCnt[i] <= seqCnt[i] + SEQ_W'(1);
            end

            afuValidQ <= accept;
            if (accept) begin
                hdrQ  <= nextHdr;
                rrPtr <= nextPtr;
            end

            rspValidQ <= rspHit;
            if (rspOk) begin
                rspDataQ <= rdBus.spl_rx_data;
                rspSeqQ  <= rxTag.seq[SEQ_W-1:0];
            end
            if (badRsp)
                errQ <= 1'b1;
        end
    end

    assign rdBus.afu_tx_rd_valid = afuValidQ;
    assign rdBus.afu_tx_rd_hdr   = hdrQ;
    assign rdBus.rsp_valid       = rspValidQ;
    assign rdBus.rsp_data        = rspDataQ;
    assign rdBus.rsp_seq         = rspSeqQ;
    assign rdBus.err_bad_id      = errQ;
    assign rdBus.idle            = (credits == '0) && !afuValidQ && !(|rspValidQ);

    // Response header fields other than the tag are not needed for steering.
    logic unusedRx;
    assign unusedRx = ^{rdBus.spl_rx_rd_hdr, rxTag.seq};

endmodule

// File: tb/tb_smem_rd_arbiter.sv
// Bench for smem_rd_arbiter: directed table and corner sequences plus a random run,
// all scored against a queue-and-counter model of the arbitration rules.
module tb_smem_rd_arbiter;
    import smem_arb_pkg::*;

    localparam int N  = 4;
    localparam int MO = 16;
    localparam int AW = 42;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    smem_rd_arbiter_if #(.N_REQ(N), .MAX_OUT(MO), .ADDR_W(AW)) bus ();

    smem_rd_arbiter #(.N_REQ(N), .MAX_OUT(MO), .ADDR_W(AW)) dut (
        .clk         (clk),
        .spl_reset_n (rstN),
        .rdBus       (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int                 mCred[N];
    int                 mSeq[N];
    int                 mPtr;
    bit                 mErr;
    bit                 eAfuV;
    t_ccip_c0_ReqMemHdr eHdr;
    logic [N-1:0]       eRspV;
    logic [511:0]       eRspD;
    int                 eRspSeq;
    logic [15:0]        outQ[$];

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mCred[i] = 0;
            mSeq[i]  = 0;
        end
        mPtr = 0; mErr = 0; eAfuV = 0; eHdr = '0;
        eRspV = '0; eRspD = '0; eRspSeq = 0;
        outQ.delete();
    endtask

    function automatic int pick();
        if (bus.spl_tx_rd_almostfull) return -1;
        for (int k = 0; k < N; k++) begin
            int r;
            r = (mPtr + k) % N;
            if (bus.req_valid[r] && mCred[r] < MO) return r;
        end
        return -1;
    endfunction

    task automatic modelUpdate();
        int          g, id;
        bit          ok;
        logic [15:0] md;
        if (!rstN) begin
            modelReset();
            return;
        end
        g  = pick();
        md = bus.spl_rx_rd_hdr.mdata;
        id = int'(md) / 8192;
        ok = bus.spl_rx_rd_valid && id < N && mCred[id] > 0;
        if (g >= 0) begin
            eAfuV = 1;
            eHdr = '0;
            eHdr.vc_sel   = eVC_VA;
            eHdr.cl_len   = eCL_LEN_1;
            eHdr.req_type = eREQ_RDLINE_S;
            eHdr.address  = bus.req_addr[g];
            eHdr.mdata    = 16'(g * 8192 + mSeq[g]);
            outQ.push_back(eHdr.mdata);
            mCred[g]++;
            mSeq[g] = (mSeq[g] + 1) % MO;
            mPtr = (g + 1) % N;
        end else begin
            eAfuV = 0;
        end
        if (ok) begin
            mCred[id]--;
            eRspV   = N'(1 << id);
            eRspD   = bus.spl_rx_data;
            eRspSeq = (int'(md) % 256) % MO;
            for (int k = 0; k < outQ.size(); k++)
                if (outQ[k] == md) begin
                    outQ.delete(k);
                    break;
                end
        end else begin
            eRspV = '0;
            if (bus.spl_rx_rd_valid) mErr = 1;
        end
    endtask

    task automatic atNeg();
        int g, sum;
        @(negedge clk);
        g = pick();
        sum = 0;
        for (int i = 0; i < N; i++) sum += mCred[i];
        chk("req_ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
        chk("afu_valid", bus.afu_tx_rd_valid, eAfuV);
        chk("afu_hdr", bus.afu_tx_rd_hdr, eHdr);
        chk("rsp_valid", bus.rsp_valid, eRspV);
        if (eRspV != 0) begin
            chk("rsp_data", bus.rsp_data, eRspD);
            chk("rsp_seq", bus.rsp_seq, eRspSeq);
        end
        chk("idle", bus.idle, (sum == 0) && !eAfuV && (eRspV == 0));
        chk("err_bad_id", bus.err_bad_id, mErr);
    endtask

    task automatic atPos();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic cyc();
        atNeg();
        atPos();
    endtask

    task automatic idleInputs();
        bus.req_valid = '0;
        bus.spl_tx_rd_almostfull = 1'b0;
        bus.spl_rx_rd_valid = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        rstN = 1'b0;
        cyc();
        rstN = 1'b1;
    endtask

    task automatic rsp(input logic [15:0] md);
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
        bus.spl_rx_rd_valid = 1'b1;
        bus.spl_rx_rd_hdr = '0;
        bus.spl_rx_rd_hdr.mdata = md;
        bus.spl_rx_data = d;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.req_valid = '0;
        while (outQ.size() > 0 && n < 300) begin
            rsp(outQ[0]);
            cyc();
            n++;
        end
        bus.spl_rx_rd_valid = 1'b0;
        chk("drain_done", outQ.size(), 0);
        cyc();
        atNeg();
        chk("drain_idle", bus.idle, 1);
        atPos();
    endtask

    // ---------------- round-robin table ----------------
    typedef struct {
        logic [N-1:0] vld;
        logic         alm;
        logic [N-1:0] expReady;
        logic         expAfu;
        int           expId;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int acc;
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b0, 0};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 0};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 1};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 3};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 0};
        tbl[6]  = '{4'b1010, 1'b0, 4'b0010, 1'b0, 0};
        tbl[7]  = '{4'b1010, 1'b0, 4'b1000, 1'b1, 1};
        tbl[8]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 3};
        tbl[9]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 2};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 0};

        bus.req_addr = '0;
        bus.spl_rx_rd_hdr = '0;
        bus.spl_rx_data = '0;
        idleInputs();
        @(posedge clk);
        modelReset();
        #1;
        doReset();

        // reset state
        atNeg();
        chk("rst_afu_valid", bus.afu_tx_rd_valid, 0);
        chk("rst_hdr", bus.afu_tx_rd_hdr, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_seq", bus.rsp_seq, 0);
        chk("rst_err", bus.err_bad_id, 0);
        chk("rst_idle", bus.idle, 1);
        atPos();

        // single request and its response
        bus.req_valid = 4'b0001;
        bus.req_addr[0] = 42'h100;
        atNeg(); chk("t1_ready", bus.req_ready, 4'b0001); atPos();
        bus.req_valid = '0;
        atNeg();
        chk("t1_afu_valid", bus.afu_tx_rd_valid, 1);
        chk("t1_addr", bus.afu_tx_rd_hdr.address, 42'h100);
        chk("t1_mdata", bus.afu_tx_rd_hdr.mdata, 16'h0000);
        chk("t1_type", bus.afu_tx_rd_hdr.req_type, eREQ_RDLINE_S);
        atPos();
        rsp(16'h0000);
        atNeg(); chk("t1_busy", bus.idle, 0); atPos();
        bus.spl_rx_rd_valid = 1'b0;
        atNeg(); chk("t1_rsp_valid", bus.rsp_valid, 4'b0001); atPos();
        atNeg(); chk("t1_idle", bus.idle, 1); atPos();

        // round-robin table
        doReset();
        for (int i = 0; i < 11; i++) begin
            bus.req_valid = tbl[i].vld;
            bus.spl_tx_rd_almostfull = tbl[i].alm;
            atNeg();
            chk("tbl_ready", bus.req_ready, tbl[i].expReady);
            chk("tbl_afu_valid", bus.afu_tx_rd_valid, tbl[i].expAfu);
            if (tbl[i].expAfu) chk("tbl_id", bus.afu_tx_rd_hdr.mdata[15:13], tbl[i].expId);
            atPos();
        end
        bus.spl_tx_rd_almostfull = 1'b0;
        drain();

        // credit limit on requester 1
        doReset();
        bus.req_valid = 4'b0010;
        repeat (16) cyc();
        atNeg(); chk("t3_block", bus.req_ready, 4'b0000); atPos();
        bus.req_valid = 4'b1111;
        atNeg(); chk("t3_other_a", bus.req_ready, 4'b0100); atPos();
        atNeg(); chk("t3_other_b", bus.req_ready, 4'b1000); atPos();
        atNeg(); chk("t3_other_c", bus.req_ready, 4'b0001); atPos();
        atNeg(); chk("t3_skip1", bus.req_ready, 4'b0100); atPos();
        bus.req_valid = '0;
        rsp(16'h2000);
        cyc();
        bus.spl_rx_rd_valid = 1'b0;
        bus.req_valid = 4'b0010;
        atNeg(); chk("t3_regrant", bus.req_ready, 4'b0010); atPos();
        drain();

        // almost-full hold-off
        doReset();
        bus.req_valid = 4'b0001;
        cyc();
        bus.req_valid = 4'b1111;
        bus.spl_tx_rd_almostfull = 1'b1;
        repeat (5) begin
            atNeg(); chk("t4_alm_ready", bus.req_ready, 4'b0000); atPos();
        end
        atNeg(); chk("t4_alm_afu", bus.afu_tx_rd_valid, 0);
        bus.spl_tx_rd_almostfull = 1'b0;
        #1;
        chk("t4_resume", bus.req_ready, 4'b0010);
        atPos();
        drain();

        // same-cycle accept and response on requester 2 at credit 7
        doReset();
        bus.req_valid = 4'b0100;
        repeat (7) cyc();
        rsp(16'h4000);
        atNeg(); chk("t5_ready", bus.req_ready, 4'b0100); atPos();
        bus.spl_rx_rd_valid = 1'b0;
        atNeg();
        chk("t5_rsp_valid", bus.rsp_valid, 4'b0100);
        chk("t5_afu_valid", bus.afu_tx_rd_valid, 1);
        acc = 0;
        if (bus.req_ready[2]) acc++;
        atPos();
        repeat (9) begin
            atNeg();
            if (bus.req_ready[2]) acc++;
            atPos();
        end
        chk("t5_credit_room", acc, 9);
        drain();

        // out-of-range ID, then response with no credit
        doReset();
        rsp(16'hC000);
        cyc();
        bus.spl_rx_rd_valid = 1'b0;
        atNeg();
        chk("t6_bad_rsp", bus.rsp_valid, 0);
        chk("t6_err", bus.err_bad_id, 1);
        atPos();
        repeat (3) cyc();
        atNeg(); chk("t6_sticky", bus.err_bad_id, 1); atPos();
        doReset();
        atNeg(); chk("t6_err_clr", bus.err_bad_id, 0); atPos();
        rsp(16'h0000);
        cyc();
        bus.spl_rx_rd_valid = 1'b0;
        atNeg();
        chk("t6_nocred_rsp", bus.rsp_valid, 0);
        chk("t6_nocred_err", bus.err_bad_id, 1);
        atPos();
        doReset();

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            bus.req_valid = N'($urandom());
            for (int r = 0; r < N; r++) bus.req_addr[r] = AW'({$urandom(), $urandom()});
            bus.spl_tx_rd_almostfull = ($urandom_range(0, 4) == 0);
            if (outQ.size() > 0 && $urandom_range(0, 2) != 0)
                rsp(outQ[$urandom_range(0, outQ.size() - 1)]);
            else if ($urandom_range(0, 49) == 0)
                rsp({3'($urandom_range(N, 7)), 13'($urandom())});
            else
                bus.spl_rx_rd_valid = 1'b0;
            cyc();
        end
        bus.spl_tx_rd_almostfull = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/smem_rd_arbiter.md
# smem_rd_arbiter

Shares the single CCI-P c0 read-request channel among N_REQ SMEM pipeline requesters inside afu_top, between the pipeline stages and the MPF-facing `afu_tx_rd_*` / `spl_rx_rd_*` ports. It performs round-robin arbitration under almost-full backpressure and stamps each request's mdata with the requester ID and a sequence number. It limits per-requester outstanding reads with credit counters and steers each read response back to the requester that issued it.

## Interface
- N_REQ, 4: number of requesters; legal values 2..8.
- MAX_OUT, 16: maximum outstanding reads per requester; power of two, ≤ 256.
- ADDR_W, 42: cache-line address width, matching t_ccip_clAddr.
---
- clk  in  1  AFU clock.
- spl_reset_n  in  1  reset; synchronous, active-low.
- req_valid  in  N_REQ  per-requester read request.
- req_addr  in  N_REQ×ADDR_W  per-requester line address.
- req_ready  out  N_REQ  request accepted this cycle when it is high together with req_valid.
- spl_tx_rd_almostfull  in  1  c0TxAlmFull from MPF.
- afu_tx_rd_valid  out  1  registered c0 request valid.
- afu_tx_rd_hdr  out  t_ccip_c0_ReqMemHdr  registered request header.
- spl_rx_rd_valid  in  1  c0 read response valid (rspValid).
- spl_rx_rd_hdr  in  t_ccip_c0_RspMemHdr  response header.
- spl_rx_data  in  512  response cache line.
- rsp_valid  out  N_REQ  one-hot response strobe.
- rsp_data  out  512  registered response data, common to all requesters.
- rsp_seq  out  log2(MAX_OUT)  sequence number echoed from mdata.
- idle  out  1  no requests are outstanding and no output is pending.
- err_bad_id  out  1  sticky: a response carried an out-of-range ID.

## Operation
- eligible[i] = req_valid[i] && credits[i] < MAX_OUT.
- The grant is the round-robin winner among eligible requesters, starting the search at pointer `rr_ptr`.
- Nothing is issued in any cycle where spl_tx_rd_almostfull = 1; all req_ready outputs are 0 in that cycle.
- req_ready is one-hot or zero. It is combinational from req_valid, credits, rr_ptr and almostfull.
- On accept by winner w:
  - rr_ptr ← (w+1) mod N_REQ.
  - credits[w] increments.
  - seq[w] increments, wrapping modulo MAX_OUT.
  - The header is registered next cycle with: address = req_addr[w], req_type = eREQ_RDLINE_S, vc_sel = eVC_VA, cl_len = eCL_LEN_1, mdata = {zero pad, ID(3b) at [15:13], seq[w] at [7:0]}.
- With no accept, afu_tx_rd_valid ← 0 and the header holds its previous value.
- On spl_rx_rd_valid:
  - id = mdata[15:13].
  - If id < N_REQ, the next cycle has rsp_valid[id] = 1, rsp_data = spl_rx_data and rsp_seq = mdata[7:0], and credits[id] decrements.
  - Otherwise the response is dropped, err_bad_id is set and no credit changes.
- When an accept and a response hit the same requester in the same cycle, its credit count is unchanged.
- A response arriving with credits[id] = 0 is dropped and sets err_bad_id; the counter never underflows.
- idle = (all credits = 0) && !afu_tx_rd_valid && !(|rsp_valid).
- Reset mid-operation discards all in-flight accounting. The integrator must hold reset until the CCI-P channel is drained.

## Timing
- Reset (spl_reset_n = 0 at a clk edge) forces: afu_tx_rd_valid = 0, afu_tx_rd_hdr = 0, rsp_valid = 0, rsp_data = 0, rsp_seq = 0, err_bad_id = 0, rr_ptr = 0, all credits and seq = 0. idle = 1 after reset.
- Request latency: accept at cycle t gives afu_tx_rd_valid = 1 at t+1.
- Response latency: spl_rx_rd_valid at cycle t gives rsp_valid at t+1.
- Throughput: one request per cycle and one response per cycle, concurrently.
- Almostfull is used in the same cycle it is sampled. MPF's almost-full slack absorbs the one registered request already in flight.
- The responses on rsp_* have no backpressure. Requesters must always accept them.

## Structure
- Package smem_arb_pkg holds: ARB_ID_W = 3, ARB_SEQ_W = 8, the mdata bit positions, the typedef t_arb_tag {id, seq}, and the functions arb_pack_mdata / arb_unpack_mdata.
- Sub-module smem_rr_arbiter is parameterised by N and is purely a round-robin grant. It takes eligible, ptr and enable, and outputs a one-hot grant and its encoded index. It is reused by the write-side arbiter.
- The top level holds the credit and seq counter arrays, the header register and the response steering register.

## Test plan
- Single requester 0 issues address 0x100 → afu_tx_rd_valid one cycle later with address 0x100 and mdata 0x0000. The response echoing mdata 0x0000 → rsp_valid = 0001 one cycle later; credits return to 0 and idle = 1.
- All four requesters hold req_valid continuously with no almostfull → grants in the order 0,1,2,3,0,… one per cycle, and mdata IDs cycle 0..3.
- Requester 1 issues 16 reads with no responses → the 17th is blocked (req_ready[1] = 0) while requesters 0, 2 and 3 are still granted. One response with ID 1 → requester 1 is granted on the next eligible cycle.
- spl_tx_rd_almostfull held high for 5 cycles with all requesters valid → no accepts in those cycles. The cycle after it drops, the grant goes to the rr_ptr holder.
- Same-cycle accept and response for requester 2 at credit 7 → credit stays 7, and rsp_valid[2] and afu_tx_rd_valid both rise next cycle.
- Response with mdata ID 6 (N_REQ = 4), and separately a response with ID 0 while credits[0] = 0 → no rsp_valid, err_bad_id = 1 and stays set until reset.
